// File: rtl/pico_io_host.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pico_io_host
// Description : Host-side bridge for the picoMIPS I/O handshake. Words from
//               a host valid/ready stream are buffered in a small FIFO. Each
//               word is presented on the processor input bus and followed by
//               a one-cycle io_handshake pulse. After a fixed settle interval
//               the processor output bus is captured into a valid/ready
//               result stream.
// Ports       : clk, n_reset        - clock, async active-low reset
//               host_in_*           - input stream (data/valid/ready)
//               host_out_*          - result stream (data/valid/ready)
//               cpu_out_bus         - processor out_bus
//               cpu_in_bus          - processor in_bus (registered)
//               io_handshake        - processor io_handshake (registered pulse)
//               busy                - sequencer is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module pico_io_host #(
   parameter int N            = 8,
   parameter int Depth        = 4,
   parameter int SettleCycles = 4
) (
   input  logic         clk,
   input  logic         n_reset,
   input  logic [N-1:0] host_in_data,
   input  logic         host_in_valid,
   output logic         host_in_ready,
   output logic [N-1:0] host_out_data,
   output logic         host_out_valid,
   input  logic         host_out_ready,
   input  logic [N-1:0] cpu_out_bus,
   output logic [N-1:0] cpu_in_bus,
   output logic         io_handshake,
   output logic         busy
);

   localparam int c_AW = $clog2(Depth);
   // Counter needs at least one bit even when SettleCycles is 1.
   localparam int c_CW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
   localparam logic [c_AW:0]   c_FULL = Depth[c_AW:0];
   localparam logic [c_CW-1:0] c_SETTLE_LOAD = c_CW'(SettleCycles - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SETUP    = 3'd1,
      S_PULSE    = 3'd2,
      S_SETTLE   = 3'd3,
      S_WAIT_OUT = 3'd4
   } state_t;

   state_t r_state;
   state_t w_next_state;

   // FIFO storage and bookkeeping
   logic [N-1:0]  r_mem [Depth];
   logic [c_AW-1:0] r_wptr;
   logic [c_AW-1:0] r_rptr;
   logic [c_AW:0]   r_count;

   logic [c_CW-1:0] r_settle;
   logic [N-1:0]    r_cpu_in;
   logic            r_hs;
   logic [N-1:0]    r_out_data;
   logic            r_out_valid;

   logic w_push;
   logic w_pop;
   logic w_load_in;
   logic w_set_hs;
   logic w_capture;
   logic w_accept;
   logic w_dec;
   logic [N-1:0] w_head;

   // Readiness comes from the registered count only, so a pop in the same
   // cycle never lets a full FIFO take a word.
   assign host_in_ready = (r_count != c_FULL);
   assign w_push        = host_in_valid && host_in_ready;
   assign w_head        = r_mem[r_rptr];

   // ------------------------------------------------------------------------
   // Sequencer: next state and per-state strobes
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_load_in    = 1'b0;
      w_set_hs     = 1'b0;
      w_pop        = 1'b0;
      w_capture    = 1'b0;
      w_accept     = 1'b0;
      w_dec        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_count != '0) begin
               w_load_in    = 1'b1;
               w_next_state = S_SETUP;
            end
         end
         S_SETUP: begin
            w_set_hs     = 1'b1;
            w_next_state = S_PULSE;
         end
         S_PULSE: begin
            // PULSE is only reachable with a non-empty FIFO.
            w_pop        = 1'b1;
            w_next_state = S_SETTLE;
         end
         S_SETTLE: begin
            if (r_settle == '0) begin
               w_capture    = 1'b1;
               w_next_state = S_WAIT_OUT;
            end else begin
               w_dec = 1'b1;
            end
         end
         S_WAIT_OUT: begin
            if (host_out_ready) begin
               w_accept     = 1'b1;
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_cpu_in    <= '0;
         r_hs        <= 1'b0;
         r_settle    <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
      end else begin
         // High only for the PULSE cycle that follows SETUP.
         r_hs <= w_set_hs;
         if (w_load_in) begin
            r_cpu_in <= w_head;
         end
         if (w_pop) begin
            r_settle <= c_SETTLE_LOAD;
         end else if (w_dec) begin
            r_settle <= r_settle - 1'b1;
         end
         if (w_capture) begin
            r_out_data  <= cpu_out_bus;
            r_out_valid <= 1'b1;
         end else if (w_accept) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // FIFO
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= host_in_data;
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         // Depth is a power of two, so pointers wrap by natural overflow.
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign cpu_in_bus     = r_cpu_in;
   assign io_handshake   = r_hs;
   assign host_out_data  = r_out_data;
   assign host_out_valid = r_out_valid;
   assign busy           = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pico_io_host.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pico_io_host
// Description : Self-checking bench for pico_io_host. A transaction-level
//               reference model predicts every output each cycle; directed
//               sequences add literal expectations for latency, FIFO limits,
//               backpressure, settle sampling and mid-transaction reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pico_io_host;

   localparam int N      = 8;
   localparam int DEPTH  = 4;
   localparam int SETTLE = 4;

   logic         clk = 1'b0;
   logic         n_reset = 1'b1;
   logic [N-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] out_data;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] cpu_out;
   logic [N-1:0] cpu_out_r;
   logic         echo;
   logic [N-1:0] cpu_in;
   logic         hs;
   logic         busy;

   // Second instance with a one-cycle settle window
   logic [N-1:0] in1_data;
   logic         in1_valid;
   logic         in1_ready;
   logic [N-1:0] out1_data;
   logic         out1_valid;
   logic         out1_ready;
   logic [N-1:0] cpu1_out;
   logic [N-1:0] cpu1_in;
   logic         hs1;
   logic         busy1;

   int total = 0;
   int bad   = 0;
   int hs_cnt = 0;

   always #5 clk = ~clk;

   // Processor stand-in: either a free driven value or an echo of its input.
   assign cpu_out = echo ? ~cpu_in : cpu_out_r;

   pico_io_host #(.N(N), .Depth(DEPTH), .SettleCycles(SETTLE)) u_dut (
      .clk            (clk),
      .n_reset        (n_reset),
      .host_in_data   (in_data),
      .host_in_valid  (in_valid),
      .host_in_ready  (in_ready),
      .host_out_data  (out_data),
      .host_out_valid (out_valid),
      .host_out_ready (out_ready),
      .cpu_out_bus    (cpu_out),
      .cpu_in_bus     (cpu_in),
      .io_handshake   (hs),
      .busy           (busy)
   );

   pico_io_host #(.N(N), .Depth(DEPTH), .SettleCycles(1)) u_dut_s1 (
      .clk            (clk),
      .n_reset        (n_reset),
      .host_in_data   (in1_data),
      .host_in_valid  (in1_valid),
      .host_in_ready  (in1_ready),
      .host_out_data  (out1_data),
      .host_out_valid (out1_valid),
      .host_out_ready (out1_ready),
      .cpu_out_bus    (cpu1_out),
      .cpu_in_bus     (cpu1_in),
      .io_handshake   (hs1),
      .busy           (busy1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   always @(negedge clk) begin
      if (hs) hs_cnt++;
   end

   // ------------------------------------------------------------------------
   // Reference model. A transaction starts one edge after the FIFO is seen
   // non-empty while idle; "age" counts edges since that start: the pulse
   // rises at age 1, the word leaves the FIFO at age 2, the output bus is
   // sampled SettleCycles edges after that, then the result waits for the
   // host before the next transaction may start.
   // ------------------------------------------------------------------------
   logic [N-1:0] mq[$];
   int           age = -1;
   logic [N-1:0] e_cpu_in = '0;
   logic [N-1:0] e_out_data = '0;
   bit           e_hs = 1'b0;
   bit           e_valid = 1'b0;
   bit           m_push;

   always @(posedge clk) begin
      if (!n_reset) begin
         mq.delete();
         age        = -1;
         e_cpu_in   = '0;
         e_out_data = '0;
         e_hs       = 1'b0;
         e_valid    = 1'b0;
      end else begin
         m_push = in_valid && (mq.size() != DEPTH);
         if (age < 0) begin
            if (mq.size() != 0) begin
               age      = 0;
               e_cpu_in = mq[0];
            end
         end else if (age == 0) begin
            e_hs = 1'b1;
            age  = 1;
         end else if (age == 1) begin
            e_hs = 1'b0;
            void'(mq.pop_front());
            age  = 2;
         end else if (!e_valid) begin
            if (age == SETTLE + 1) begin
               e_out_data = cpu_out;
               e_valid    = 1'b1;
            end else begin
               age++;
            end
         end else if (out_ready) begin
            e_valid = 1'b0;
            age     = -1;
         end
         if (m_push) mq.push_back(in_data);
      end
      #1;
      chk("cpu_in_bus",     32'(cpu_in),    32'(e_cpu_in));
      chk("io_handshake",   32'(hs),        32'(e_hs));
      chk("host_out_valid", 32'(out_valid), 32'(e_valid));
      chk("host_out_data",  32'(out_data),  32'(e_out_data));
      chk("busy",           32'(busy),      32'(age >= 0));
      chk("host_in_ready",  32'(in_ready),  32'(mq.size() != DEPTH));
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] got[$];
      logic [N-1:0] exp_list [6];
      int           hs_snap;
      bit           accepted;

      in_valid   = 1'b0;
      in_data    = '0;
      out_ready  = 1'b1;
      cpu_out_r  = 8'hC3;
      echo       = 1'b0;
      in1_valid  = 1'b0;
      in1_data   = '0;
      out1_ready = 1'b1;
      cpu1_out   = 8'h11;

      // Reset values
      #1 n_reset = 1'b0;
      #1;
      chk("rst_cpu_in",   32'(cpu_in),    32'h0);
      chk("rst_hs",       32'(hs),        32'h0);
      chk("rst_out_data", 32'(out_data),  32'h0);
      chk("rst_valid",    32'(out_valid), 32'h0);
      chk("rst_busy",     32'(busy),      32'h0);
      chk("rst_ready",    32'(in_ready),  32'h1);
      chk("rst_ready_s1", 32'(in1_ready), 32'h1);
      #10 n_reset = 1'b1;
      tick();

      // Single word: latency pinned with literals
      in_valid = 1'b1;
      in_data  = 8'h5A;
      tick();                          // E0
      in_valid = 1'b0;
      tick();                          // E1
      chk("sw_cpu_in_e1", 32'(cpu_in), 32'h5A);
      chk("sw_hs_e1",     32'(hs),     32'h0);
      tick();                          // E2
      chk("sw_hs_e2",     32'(hs),     32'h1);
      tick();                          // E3
      chk("sw_hs_e3",     32'(hs),     32'h0);
      repeat (3) tick();               // E6
      chk("sw_valid_e6",  32'(out_valid), 32'h0);
      tick();                          // E7
      chk("sw_valid_e7",  32'(out_valid), 32'h1);
      chk("sw_data_e7",   32'(out_data),  32'hC3);
      tick();                          // E8
      chk("sw_valid_e8",  32'(out_valid), 32'h0);
      chk("sw_busy_e8",   32'(busy),      32'h0);

      // Settle sampling with SettleCycles=1
      in1_valid = 1'b1;
      in1_data  = 8'h33;
      tick();                          // E0
      in1_valid = 1'b0;
      tick();                          // E1
      tick();                          // E2
      chk("s1_hs_e2", 32'(hs1), 32'h1);
      tick();                          // E3
      cpu1_out = 8'h22;
      tick();                          // E4
      chk("s1_valid_e4", 32'(out1_valid), 32'h1);
      chk("s1_data_e4",  32'(out1_data),  32'h22);
      cpu1_out = 8'h44;
      tick();                          // E5: accepted, data held
      chk("s1_valid_e5", 32'(out1_valid), 32'h0);
      chk("s1_data_e5",  32'(out1_data),  32'h22);

      // FIFO full with the sequencer stalled on an unaccepted result
      out_ready = 1'b0;
      cpu_out_r = 8'hA7;
      in_valid  = 1'b1;
      in_data   = 8'hEE;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 20 && !out_valid; i++) tick();
      chk("stall_valid", 32'(out_valid), 32'h1);
      for (int w = 1; w <= 4; w++) begin
         in_valid = 1'b1;
         in_data  = 8'(w);
         tick();
      end
      chk("full_ready", 32'(in_ready), 32'h0);
      in_data = 8'h05;
      hs_snap = hs_cnt;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_valid", 32'(out_valid), 32'h1);
         chk("bp_data",  32'(out_data),  32'hA7);
         chk("bp_ready", 32'(in_ready),  32'h0);
      end
      chk("bp_no_pulse", 32'(hs_cnt), 32'(hs_snap));
      echo      = 1'b1;
      out_ready = 1'b1;
      accepted  = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (in_ready) accepted = 1'b1;
         if (out_valid) got.push_back(out_data);
         tick();
         if (accepted) break;
      end
      in_valid = 1'b0;
      chk("fifth_accepted", 32'(accepted), 32'h1);
      for (int i = 0; i < 200 && got.size() < 6; i++) begin
         if (out_valid) got.push_back(out_data);
         tick();
      end
      exp_list = '{8'hA7, 8'hFE, 8'hFD, 8'hFC, 8'hFB, 8'hFA};
      chk("order_count", 32'(got.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < got.size()) chk("order_word", 32'(got[i]), 32'(exp_list[i]));
      end
      chk("order_pulses", 32'(hs_cnt), 32'(hs_snap + 5));
      echo = 1'b0;

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom_range(0, 1) == 1);
         in_data   = 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         cpu_out_r = 8'($urandom);
         echo      = ($urandom_range(0, 7) == 0);
         tick();
      end

      // Drain, then reset in the middle of a settle window
      in_valid  = 1'b0;
      out_ready = 1'b1;
      echo      = 1'b0;
      for (int i = 0; i < 200 && (age >= 0 || mq.size() != 0); i++) tick();
      chk("drained", 32'(busy), 32'h0);
      for (int w = 0; w < 3; w++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'h70 + w);
         tick();                       // R0..R2
      end
      in_valid = 1'b0;
      tick();                          // R3: word popped, settling, 2 left
      chk("mid_busy", 32'(busy), 32'h1);
      n_reset = 1'b0;
      #1;
      chk("mid_rst_cpu_in", 32'(cpu_in),    32'h0);
      chk("mid_rst_hs",     32'(hs),        32'h0);
      chk("mid_rst_data",   32'(out_data),  32'h0);
      chk("mid_rst_valid",  32'(out_valid), 32'h0);
      chk("mid_rst_busy",   32'(busy),      32'h0);
      chk("mid_rst_ready",  32'(in_ready),  32'h1);
      tick();
      tick();
      n_reset = 1'b1;
      hs_snap = hs_cnt;
      repeat (30) tick();
      chk("post_rst_no_pulse", 32'(hs_cnt), 32'(hs_snap));
      chk("post_rst_busy",     32'(busy),   32'h0);
      chk("s1_busy_end",       32'(busy1),  32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
